// File: rtl/sw_debounce_in.sv
// sw_debounce_in: board switch input conditioner.
// Synchronises the raw active-low switch bus to clk, debounces each bit on a
// prescaled sample tick and presents an active-high level together with
// one-cycle rise/fall pulses and a sticky change event (evt_valid/evt_ack).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   sw_raw     raw switch pins, active-low, asynchronous to clk
//   sw_level   debounced level, active-high
//   sw_rise    one-cycle pulse per bit on a 0->1 level change
//   sw_fall    one-cycle pulse per bit on a 1->0 level change
//   evt_valid  sticky: some level bit changed since the last ack
//   evt_ack    clears evt_valid (a change in the same cycle wins)
module sw_debounce_in #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             evt_valid,
    input  logic             evt_ack
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CntW = $clog2(STABLE_TICKS) + 1;
    localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, fall_q;
    logic [PreW-1:0]  pre_q, pre_d;
    logic             tick;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic             evt_q, evt_d;

    // Synchronised, inverted to active-high.
    assign cand = ~sync2_q;

    always_comb begin
        tick  = (pre_q == PreMax);
        pre_d = tick ? '0 : pre_q + PreW'(1);

        level_d = level_q;
        cnt_d   = cnt_q;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (cand[i] == level_q[i]) begin
                    // Any agreeing sample restarts the stability run.
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    level_d[i] = cand[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end

        // A change reported this cycle takes priority over an ack.
        if (|(rise_q | fall_q)) begin
            evt_d = 1'b1;
        end else if (evt_ack) begin
            evt_d = 1'b0;
        end else begin
            evt_d = evt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pre_q   <= '0;
            evt_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            // Pulses are registered alongside the level they describe.
            rise_q  <= level_d & ~level_q;
            fall_q  <= level_q & ~level_d;
            pre_q   <= pre_d;
            evt_q   <= evt_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_level  = level_q;
    assign sw_rise   = rise_q;
    assign sw_fall   = fall_q;
    assign evt_valid = evt_q;

endmodule

// File: doc/sw_debounce_in.md
Name: sw_debounce_in

Overview:
- Sequential input-side counterpart to the active-low LED output adapter.
- Takes the raw active-low switch/button bus from the board and synchronises it to clk.
- Debounces each bit and presents clean active-high levels to the datapath, plus one-cycle rise/fall pulses and a sticky change event with request/acknowledge handshake.
- Sits between the board pins and the combinational input adapters.

Parameters:
- WIDTH, 32, number of switch bits handled.
- TICK_DIV, 50000, clk cycles per debounce sample tick; must be ≥2.
- STABLE_TICKS, 4, consecutive differing samples required to accept a new level; must be ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- sw_raw  input  WIDTH  raw switch pins, active-low (0 = pressed/on), asynchronous to clk.
- sw_level  output  WIDTH  debounced, active-high level (1 = pressed/on).
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_level goes 0→1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_level goes 1→0.
- evt_valid  output  1  sticky flag: at least one sw_level bit changed since last ack.
- evt_ack  input  1  clears evt_valid.

Behaviour:
- Reset:
  - Applied when rst_n=0 at a clk edge; clk is the only clock and reset is synchronous and active-low.
  - 2-stage synchroniser regs = all ones (inactive raw); sw_level=0; sw_rise=0; sw_fall=0; evt_valid=0; prescaler=0; all per-bit counters=0.
  - A reset asserted mid-debounce discards partial counts; no pulses are emitted on reset exit.
- Synchroniser:
  - sw_raw passes through 2 flops, then is inverted: cand = ~sync2, active-high.
  - No logic reads sw_raw directly.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for the single cycle where the count equals TICK_DIV-1.
- Per-bit debounce, evaluated only on tick cycles:
  - cand[i]==sw_level[i]: cnt[i] ← 0.
  - cand[i]!=sw_level[i] and cnt[i]==STABLE_TICKS-1: sw_level[i] ← cand[i], cnt[i] ← 0, and the matching pulse is asserted the next cycle (the registered cycle where sw_level changes).
  - Otherwise: cnt[i] ← cnt[i]+1.
  - Counter width is clog2(STABLE_TICKS)+1 and must never overflow.
- Pulses:
  - sw_rise[i] = new level 1; sw_fall[i] = new level 0.
  - High for exactly one clk, aligned with the sw_level update. Both are 0 on all non-update cycles.
- Latency: a clean raw edge appears on sw_level between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV+1 cycles later.
- Glitches: any sample agreeing with the current level restarts that bit's count. Bounces shorter than STABLE_TICKS ticks never change sw_level.
- Independence: bits debounce independently. Several bits may change in the same cycle, and their pulses then assert together.
- Event handshake:
  - evt_valid set on any cycle where any sw_rise|sw_fall bit is 1.
  - evt_valid cleared on a cycle with evt_ack=1 and no new change.
  - Simultaneous change and ack: set wins, evt_valid stays 1 and the new change is not lost.
  - evt_ack while evt_valid=0 is ignored.

Test Plan (TICK_DIV=4, STABLE_TICKS=3, WIDTH=32):
- Reset:
  - Stimulus: rst_n=0 for 3 cycles with sw_raw=32'h0 (all pressed).
  - Required: sw_level=0, pulses=0, evt_valid=0 during reset.
  - After release: sw_level=32'hFFFFFFFF within 2+12+1 cycles, exactly one sw_rise=32'hFFFFFFFF pulse, evt_valid=1.
- Clean press:
  - Stimulus: from all released, sw_raw bit 3 → 0 and held.
  - Required: sw_level=32'h8 within 11–15 cycles; one-cycle sw_rise=32'h8; sw_fall=0.
- Bounce rejection:
  - Stimulus: bit 0 toggles every 5 cycles for 60 cycles, then returns to released.
  - Required: sw_level[0] stays 0, no pulses, evt_valid stays 0.
- Release with ack collision:
  - Stimulus: bit 3 pressed and evt_valid=1; release bit 3 and hold evt_ack=1 continuously.
  - Required: sw_fall=32'h8 for one cycle; evt_valid=1 on the following cycle (set wins); evt_valid cleared the cycle after that.
- Multi-bit and mid-operation reset:
  - Stimulus 1: press bits 10:0 simultaneously.
  - Required: sw_level=32'h7FF updated in a single cycle with sw_rise=32'h7FF.
  - Stimulus 2: press bit 31, then pulse rst_n=0 one cycle after 2 ticks.
  - Required: sw_level=0, and bit 31 requires a full 3 fresh ticks after reset before sw_level[31]=1.
